// File: rtl/hazard_forward_unit.sv
// Operand-forwarding selects and load-use stall from shadow EX/MEM stage state.
// Optional macro MIPS_LOAD_STALL_EN enables the load-use stall and the stall_count port.
module hazard_forward_unit #(
    parameter int REG_AW = 5
`ifdef MIPS_LOAD_STALL_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwr,
    input  logic              id_load,
    output logic              ex_forward_a,
    output logic              mem_forward_a,
    output logic              ex_forward_b,
    output logic              mem_forward_b,
    output logic              stall
`ifdef MIPS_LOAD_STALL_EN
    ,output logic [CNT_W-1:0] stall_count
`endif
);

    // WB is not shadowed: its write lands in the register file before the
    // decode read, so it can never change a forward or stall decision.
    logic              ex_valid_q,  ex_valid_d;
    logic [REG_AW-1:0] ex_dst_q,    ex_dst_d;
    logic              ex_regwr_q,  ex_regwr_d;
    logic              ex_load_q,   ex_load_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_dst_q,   mem_dst_d;
    logic              mem_regwr_q, mem_regwr_d;

    logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;

    function automatic logic writes(input logic v, input logic wr,
                                    input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] r);
        return v & wr & (dst != '0) & (dst == r);
    endfunction

    always_comb begin
        ex_wr_rs  = writes(ex_valid_q,  ex_regwr_q,  ex_dst_q,  id_rs);
        ex_wr_rt  = writes(ex_valid_q,  ex_regwr_q,  ex_dst_q,  id_rt);
        mem_wr_rs = writes(mem_valid_q, mem_regwr_q, mem_dst_q, id_rs);
        mem_wr_rt = writes(mem_valid_q, mem_regwr_q, mem_dst_q, id_rt);

        // A load in EX has no result yet, so it never forwards from EX.
        ex_forward_a  = id_valid & ex_wr_rs & ~ex_load_q;
        mem_forward_a = id_valid & mem_wr_rs & ~ex_forward_a;
        ex_forward_b  = id_valid & id_uses_rt & ex_wr_rt & ~ex_load_q;
        mem_forward_b = id_valid & id_uses_rt & mem_wr_rt & ~ex_forward_b;

`ifdef MIPS_LOAD_STALL_EN
        stall = id_valid & ex_load_q & (ex_wr_rs | (id_uses_rt & ex_wr_rt));
`else
        stall = 1'b0;
`endif
    end

    always_comb begin
        ex_valid_d  = id_valid & ~stall;
        ex_dst_d    = stall ? '0 : id_dst;
        ex_regwr_d  = id_regwr & ~stall;
        ex_load_d   = id_load & ~stall;
        mem_valid_d = ex_valid_q;
        mem_dst_d   = ex_dst_q;
        mem_regwr_d = ex_regwr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_dst_q    <= '0;
            ex_regwr_q  <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dst_q   <= '0;
            mem_regwr_q <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_dst_q    <= ex_dst_d;
            ex_regwr_q  <= ex_regwr_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_dst_q   <= mem_dst_d;
            mem_regwr_q <= mem_regwr_d;
        end
    end

`ifdef MIPS_LOAD_STALL_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
`endif

endmodule
